// File: rtl/zion_basic_circuit_lib_pkg.sv
// Shared types and helpers for the zion basic circuit library.
// Holds the sequencer state encoding and a constant max() used for counter sizing.
package zion_basic_circuit_lib_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, STAGE, DONE} state_e;

  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/zion_basic_circuit_lib_rst_seq_if.sv
// Handshake bundle between the reset sequencer (master) and the banks it drives (slave).
// iAck exists only when ZION_BASIC_CIRCUIT_LIB_RST_SEQ_ACK_EN is defined.
interface zion_basic_circuit_lib_rst_seq_if #(
  parameter int STAGE_NUM = 4
);
  localparam int SW = $clog2(STAGE_NUM + 1);

  logic                 iSoftRst;
`ifdef ZION_BASIC_CIRCUIT_LIB_RST_SEQ_ACK_EN
  logic [STAGE_NUM-1:0] iAck;
`endif
  logic [STAGE_NUM-1:0] oRst;
  logic [SW-1:0]        oStage;
  logic                 oDone;

`ifdef ZION_BASIC_CIRCUIT_LIB_RST_SEQ_ACK_EN
  modport master (input iSoftRst, input iAck, output oRst, output oStage, output oDone);
  modport slave  (output iSoftRst, output iAck, input oRst, input oStage, input oDone);
`else
  modport master (input iSoftRst, output oRst, output oStage, output oDone);
  modport slave  (output iSoftRst, input oRst, input oStage, input oDone);
`endif

endinterface

// File: rtl/zion_basic_circuit_lib_rst_sync.sv
// Two-flop reset synchronizer: asserts asynchronously, releases on the second clk edge.
// OUT_POS selects the asserted level of oRst.
module zion_basic_circuit_lib_rst_sync #(
  parameter int OUT_POS = 1
) (
  input  logic clk,
  input  logic rst,
  output logic oRst
);
  localparam logic POL = (OUT_POS != 0);

  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {2{POL}};
    end else begin
      sync_q <= {sync_q[0], ~POL};
    end
  end

  assign oRst = sync_q[1];

endmodule

// File: rtl/zion_basic_circuit_lib_rst_seq.sv
// Staged reset sequencer: releases STAGE_NUM bank resets in index order after a hold time.
// Macros: ZION_BASIC_CIRCUIT_LIB_RST_SEQ_ACK_EN (per-stage ack gating), CHECK_ERR_EXIT.
module zion_basic_circuit_lib_rst_seq
  import zion_basic_circuit_lib_pkg::*;
#(
  parameter int STAGE_NUM = 4,
  parameter int HOLD_CYC  = 8,
  parameter int GAP_CYC   = 2,
  parameter int OUT_POS   = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  zion_basic_circuit_lib_rst_seq_if.master bus
);
  localparam int CW = $clog2(max(HOLD_CYC, GAP_CYC) + 1);
  localparam int SW = $clog2(STAGE_NUM + 1);
  localparam logic POL = (OUT_POS != 0);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_MAX   = CW'(GAP_CYC);
  localparam logic [SW-1:0] LAST_STG  = SW'(STAGE_NUM - 1);
  localparam logic [SW-1:0] ALL_STG   = SW'(STAGE_NUM);
`ifdef ZION_BASIC_CIRCUIT_LIB_RST_SEQ_ACK_EN
  localparam logic ACK_EN = 1'b1;
`else
  localparam logic ACK_EN = 1'b0;
`endif

  if (STAGE_NUM < 1 || HOLD_CYC < 1 || GAP_CYC < 1 || (OUT_POS != 0 && OUT_POS != 1))
  begin : g_bad_param
`ifdef CHECK_ERR_EXIT
    $fatal(1, "zion_basic_circuit_lib_rst_seq: illegal parameter value");
`else
    $error("zion_basic_circuit_lib_rst_seq: illegal parameter value");
`endif
  end

  logic rst_sync;

  zion_basic_circuit_lib_rst_sync #(
    .OUT_POS(1)
  ) u_rst_sync (
    .clk  (clk),
    .rst  (rst),
    .oRst (rst_sync)
  );

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d, gap_next;
  logic [SW-1:0]        stage_q, stage_d;
  logic [STAGE_NUM-1:0] orst_q, orst_d;
  logic                 ack_prev, ack_last;

  // Without the ack feature both gates are permanently open.
  always_comb begin
    ack_prev = 1'b1;
    ack_last = 1'b1;
`ifdef ZION_BASIC_CIRCUIT_LIB_RST_SEQ_ACK_EN
    ack_prev = 1'b0;
    ack_last = bus.iAck[STAGE_NUM-1];
    for (int i = 0; i < STAGE_NUM; i++) begin
      if (stage_q == SW'(i + 1)) ack_prev = bus.iAck[i];
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stage_d  = stage_q;
    gap_next = (cnt_q >= GAP_MAX) ? GAP_MAX : cnt_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (!rst_sync) begin
          state_d = HOLD;
          cnt_d   = '0;
          stage_d = '0;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          stage_d = SW'(1);
          state_d = (STAGE_NUM == 1 && !ACK_EN) ? DONE : STAGE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STAGE: begin
        cnt_d = gap_next;
        if (stage_q == ALL_STG) begin
          // Only reachable with acks: all released, waiting for the last bank.
          if (ack_last) state_d = DONE;
        end else if (gap_next == GAP_MAX && ack_prev) begin
          cnt_d   = '0;
          stage_d = stage_q + 1'b1;
          if (stage_q == LAST_STG && !ACK_EN) state_d = DONE;
        end
      end
      DONE: begin
        if (!ack_last) state_d = STAGE;
      end
    endcase

    if (bus.iSoftRst && state_q != IDLE) begin
      state_d = HOLD;
      cnt_d   = '0;
      stage_d = '0;
    end
  end

  // Registered decode keeps oRst glitch-free on release.
  always_comb begin
    orst_d = '0;
    for (int i = 0; i < STAGE_NUM; i++) begin
      orst_d[i] = (SW'(i) >= stage_d) ? POL : ~POL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stage_q <= '0;
      orst_q  <= {STAGE_NUM{POL}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      orst_q  <= orst_d;
    end
  end

  assign bus.oRst   = orst_q;
  assign bus.oStage = stage_q;
  assign bus.oDone  = (state_q == DONE);

endmodule

// File: tb/tb_zion_basic_circuit_lib_rst_seq.sv
// Directed bench: default sequencer plus a single-stage, active-low, one-cycle-hold instance.
module tb_zion_basic_circuit_lib_rst_seq;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  zion_basic_circuit_lib_rst_seq_if #(.STAGE_NUM(4)) bus_a ();
  zion_basic_circuit_lib_rst_seq_if #(.STAGE_NUM(1)) bus_b ();

  zion_basic_circuit_lib_rst_seq #(
    .STAGE_NUM (4),
    .HOLD_CYC  (8),
    .GAP_CYC   (2),
    .OUT_POS   (1)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  zion_basic_circuit_lib_rst_seq #(
    .STAGE_NUM (1),
    .HOLD_CYC  (1),
    .GAP_CYC   (2),
    .OUT_POS   (0)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle on the following falling edge.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus_a.iSoftRst = 1'b0;
    bus_b.iSoftRst = 1'b0;
`ifdef ZION_BASIC_CIRCUIT_LIB_RST_SEQ_ACK_EN
    bus_a.iAck = '1;
    bus_b.iAck = '1;
`endif
    edges(3);
    chk("rst_a_orst", 32'(bus_a.oRst), 32'hF);
    chk("rst_a_stage", 32'(bus_a.oStage), 32'd0);
    chk("rst_a_done", 32'(bus_a.oDone), 32'd0);
    chk("rst_b_orst", 32'(bus_b.oRst), 32'd0);
    chk("rst_b_done", 32'(bus_b.oDone), 32'd0);

    // Test 1: release before E0; T0 is the third edge.
    rst = 1'b0;
    edges(2);
    chk("t1_sync_orst", 32'(bus_a.oRst), 32'hF);
    edges(1);
    chk("t1_t0_orst", 32'(bus_a.oRst), 32'hF);
    chk("t4_t0_b_orst", 32'(bus_b.oRst), 32'd0);
    chk("t4_t0_b_done", 32'(bus_b.oDone), 32'd0);
    edges(1);
    chk("t4_t1_b_orst", 32'(bus_b.oRst), 32'd1);
    chk("t4_t1_b_done", 32'(bus_b.oDone), 32'd1);
    chk("t4_t1_b_stage", 32'(bus_b.oStage), 32'd1);
    edges(6);
    chk("t1_t7_orst", 32'(bus_a.oRst), 32'hF);
    chk("t1_t7_stage", 32'(bus_a.oStage), 32'd0);
    edges(1);
    chk("t1_t8_orst", 32'(bus_a.oRst), 32'hE);
    chk("t1_t8_stage", 32'(bus_a.oStage), 32'd1);
    edges(1);
    chk("t1_t9_orst", 32'(bus_a.oRst), 32'hE);
    edges(1);
    chk("t1_t10_orst", 32'(bus_a.oRst), 32'hC);
    chk("t1_t10_stage", 32'(bus_a.oStage), 32'd2);
    edges(2);
    chk("t1_t12_orst", 32'(bus_a.oRst), 32'h8);
    chk("t1_t12_stage", 32'(bus_a.oStage), 32'd3);
    edges(1);
    chk("t1_t13_done", 32'(bus_a.oDone), 32'd0);
    edges(1);
    chk("t1_t14_orst", 32'(bus_a.oRst), 32'h0);
    chk("t1_t14_stage", 32'(bus_a.oStage), 32'd4);
    chk("t1_t14_done", 32'(bus_a.oDone), 32'd1);
    edges(3);
    chk("t1_hold_done", 32'(bus_a.oDone), 32'd1);
    chk("t1_hold_stage", 32'(bus_a.oStage), 32'd4);

    // Test 2: soft reset for three edges, release 8 edges after it falls.
    bus_a.iSoftRst = 1'b1;
    edges(1);
    chk("t2_s1_orst", 32'(bus_a.oRst), 32'hF);
    chk("t2_s1_stage", 32'(bus_a.oStage), 32'd0);
    chk("t2_s1_done", 32'(bus_a.oDone), 32'd0);
    edges(2);
    chk("t2_s3_orst", 32'(bus_a.oRst), 32'hF);
    bus_a.iSoftRst = 1'b0;
    edges(7);
    chk("t2_r7_orst", 32'(bus_a.oRst), 32'hF);
    chk("t2_r7_stage", 32'(bus_a.oStage), 32'd0);
    edges(1);
    chk("t2_r8_orst", 32'(bus_a.oRst), 32'hE);
    chk("t2_r8_stage", 32'(bus_a.oStage), 32'd1);

    // Test 3: async rst with oStage=2 takes effect before the next edge.
    edges(2);
    chk("t3_pre_orst", 32'(bus_a.oRst), 32'hC);
    chk("t3_pre_stage", 32'(bus_a.oStage), 32'd2);
    rst = 1'b1;
    #1;
    chk("t3_async_orst", 32'(bus_a.oRst), 32'hF);
    chk("t3_async_stage", 32'(bus_a.oStage), 32'd0);
    chk("t3_async_done", 32'(bus_a.oDone), 32'd0);
    chk("t3_async_b_orst", 32'(bus_b.oRst), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    edges(10);
    chk("t3_t7_orst", 32'(bus_a.oRst), 32'hF);
    edges(1);
    chk("t3_t8_orst", 32'(bus_a.oRst), 32'hE);
    edges(6);
    chk("t3_t14_orst", 32'(bus_a.oRst), 32'h0);
    chk("t3_t14_done", 32'(bus_a.oDone), 32'd1);

    // Test 6: rst dominates soft reset; soft reset in IDLE does not delay the sequence.
    bus_a.iSoftRst = 1'b1;
    rst = 1'b1;
    #1;
    chk("t6_async_orst", 32'(bus_a.oRst), 32'hF);
    chk("t6_async_stage", 32'(bus_a.oStage), 32'd0);
    chk("t6_async_done", 32'(bus_a.oDone), 32'd0);
    edges(2);
    chk("t6_rst_orst", 32'(bus_a.oRst), 32'hF);
    rst = 1'b0;
    edges(1);
    chk("t6_e0_orst", 32'(bus_a.oRst), 32'hF);
    bus_a.iSoftRst = 1'b0;
    edges(2);
    edges(7);
    chk("t6_t7_orst", 32'(bus_a.oRst), 32'hF);
    edges(1);
    chk("t6_t8_orst", 32'(bus_a.oRst), 32'hE);
    chk("t6_t8_stage", 32'(bus_a.oStage), 32'd1);
    chk("t6_b_orst", 32'(bus_b.oRst), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
